// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_ctrl
//  Description : Clocked instruction memory controller. A word-addressed
//                program store is filled through a boot load port. After
//                boot it serves byte-addressed fetches with a one-cycle
//                registered read and a valid/ready handshake. Misaligned and
//                out-of-range fetch addresses raise a sticky fault.
//
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                load_we/addr/data   - boot load write port (BOOT only)
//                load_done           - one-cycle pulse ending boot load
//                fetch_req/addr      - fetch request, byte address
//                fault_clr           - clears a fault, resumes RUN
//                fetch_ready         - fetch accepted this cycle (RUN)
//                fetch_valid         - instruction holds last cycle's fetch
//                instruction         - registered fetch data
//                fault, fault_addr   - sticky fault flag and its address
//                load_count          - words written in BOOT, saturating
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
    parameter  int WORD_SIZE = 32,
    parameter  int DEPTH     = 256,
    parameter  int ADDR_W    = 32,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_we,
    input  logic [IDX_W-1:0]     load_addr,
    input  logic [WORD_SIZE-1:0] load_data,
    input  logic                 load_done,
    input  logic                 fetch_req,
    input  logic [ADDR_W-1:0]    fetch_addr,
    input  logic                 fault_clr,
    output logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 fault,
    output logic [ADDR_W-1:0]    fault_addr,
    output logic [IDX_W:0]       load_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [IDX_W:0] c_count_max = (IDX_W+1)'(DEPTH);

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_mem [DEPTH];
    logic                   r_fetch_valid;
    logic [WORD_SIZE-1:0]   r_instruction;
    logic                   r_fault;
    logic [ADDR_W-1:0]      r_fault_addr;
    logic [IDX_W:0]         r_load_count;

    logic                   w_mem_we;
    logic                   w_fetch_acc;
    logic                   w_aligned;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_fetch_idx;

    // Ready depends on state only, never on the request itself.
    assign fetch_ready = (r_state == ST_RUN);

    // A reset cycle must not write, so words present before reset stay intact
    // and no half-cycle write sneaks in while the FSM is forced to BOOT.
    assign w_mem_we    = rst_n && (r_state == ST_BOOT) && load_we;
    assign w_fetch_acc = fetch_req && fetch_ready;

    assign w_aligned   = (fetch_addr[1:0] == 2'b00);
    // Any set bit above the word-index field points outside the store.
    assign w_in_range  = ((fetch_addr >> (IDX_W + 2)) == '0);
    assign w_fetch_idx = fetch_addr[IDX_W+1:2];

    // Program store: deliberately not reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_fetch_valid <= 1'b0;
            r_instruction <= '0;
            r_fault       <= 1'b0;
            r_fault_addr  <= '0;
            r_load_count  <= '0;
        end else begin
            // fetch_valid is a single-cycle pulse per accepted legal fetch.
            r_fetch_valid <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    if (load_we && (r_load_count != c_count_max)) begin
                        r_load_count <= r_load_count + 1'b1;
                    end
                    if (load_done) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fetch_acc) begin
                        if (w_aligned && w_in_range) begin
                            r_fetch_valid <= 1'b1;
                            r_instruction <= r_mem[w_fetch_idx];
                        end else begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= fetch_addr;
                            r_state      <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    // fault_addr is kept for post-mortem inspection.
                    if (fault_clr) begin
                        r_fault <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign instruction = r_instruction;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_ctrl
//  Description : Self-checking bench for instr_mem_ctrl. Expected fetch words
//                come from a bench-side memory model and are queued when a
//                legal fetch is driven; a negedge monitor pops and compares
//                them whenever fetch_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

    localparam int WORD_SIZE = 32;
    localparam int DEPTH     = 256;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 load_we;
    logic [IDX_W-1:0]     load_addr;
    logic [WORD_SIZE-1:0] load_data;
    logic                 load_done;
    logic                 fetch_req;
    logic [ADDR_W-1:0]    fetch_addr;
    logic                 fault_clr;
    logic                 fetch_ready;
    logic                 fetch_valid;
    logic [WORD_SIZE-1:0] instruction;
    logic                 fault;
    logic [ADDR_W-1:0]    fault_addr;
    logic [IDX_W:0]       load_count;

    int n_checks;
    int n_errors;

    logic [WORD_SIZE-1:0] mdl [DEPTH];
    logic [WORD_SIZE-1:0] sb [$];

    instr_mem_ctrl #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fault_clr  (fault_clr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .instruction(instruction),
        .fault      (fault),
        .fault_addr (fault_addr),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every fetch_valid must match a queued expectation.
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(fetch_valid), 64'd0);
            end else begin
                chk("instruction", 64'(instruction), 64'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data, input logic done);
        load_we   = 1'b1;
        load_addr = IDX_W'(idx);
        load_data = data;
        load_done = done;
        mdl[idx]  = data;
        tick();
        load_we   = 1'b0;
        load_done = 1'b0;
    endtask

    // Legal fetch in RUN: one-cycle latency, result checked by the monitor.
    task automatic fetch(input logic [31:0] addr);
        logic [7:0] idx;
        idx = addr[9:2];
        chk("ready_before_fetch", 64'(fetch_ready), 64'd1);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        sb.push_back(mdl[idx]);
        tick();
        chk("valid_latency", 64'(fetch_valid), 64'd1);
        fetch_req  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},      64'(fetch_ready), 64'd0);
        chk({tag, "_valid"},      64'(fetch_valid), 64'd0);
        chk({tag, "_instr"},      64'(instruction), 64'd0);
        chk({tag, "_fault"},      64'(fault),       64'd0);
        chk({tag, "_fault_addr"}, 64'(fault_addr),  64'd0);
        chk({tag, "_load_count"}, 64'(load_count),  64'd0);
    endtask

    task automatic drain(input string tag);
        tick();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        fault_clr  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;

        tick();
        tick();
        check_reset_state("rst");
        rst_n = 1'b1;

        // Requests during BOOT must be refused.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("boot_ready", 64'(fetch_ready), 64'd0);
            chk("boot_valid", 64'(fetch_valid), 64'd0);
        end
        fetch_req = 1'b0;

        load(0, 32'h2008_0001, 1'b0);
        load(1, 32'h2009_0002, 1'b0);
        load(2, 32'h0109_5020, 1'b0);
        load(3, 32'hAC0A_0000, 1'b0);
        chk("load_count_4", 64'(load_count), 64'd4);
        chk("boot_ready_after_load", 64'(fetch_ready), 64'd0);
        load(255, 32'h1234_5678, 1'b0);
        // Write and load_done together: the write commits, then RUN.
        load(5, 32'hDEAD_BEEF, 1'b1);
        chk("load_count_6", 64'(load_count), 64'd6);
        chk("run_ready", 64'(fetch_ready), 64'd1);

        // Back-to-back fetches.
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        drain("sb_empty_b2b");
        fetch(32'h14);
        fetch(32'h3FC);
        drain("sb_empty_edge");

        // load_we is ignored in RUN.
        load_we   = 1'b1;
        load_addr = '0;
        load_data = 32'h0;
        tick();
        load_we   = 1'b0;
        fetch(32'h0);
        drain("sb_empty_run_we");
        chk("load_count_hold", 64'(load_count), 64'd6);

        // Misaligned fetch.
        fetch_req  = 1'b1;
        fetch_addr = 32'h6;
        tick();
        fetch_req  = 1'b0;
        chk("mis_valid", 64'(fetch_valid), 64'd0);
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fault_addr", 64'(fault_addr), 64'h6);
        chk("mis_ready", 64'(fetch_ready), 64'd0);
        chk("mis_instr_hold", 64'(instruction), 64'h2008_0001);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        tick();
        tick();
        fetch_req  = 1'b0;
        chk("fault_no_resp", 64'(fetch_valid), 64'd0);
        chk("fault_sticky", 64'(fault), 64'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", 64'(fault), 64'd0);
        chk("clr_ready", 64'(fetch_ready), 64'd1);
        chk("clr_fault_addr_kept", 64'(fault_addr), 64'h6);
        fetch(32'h0);
        drain("sb_empty_clr");

        // Out-of-range fetch.
        fetch_req  = 1'b1;
        fetch_addr = 32'h400;
        tick();
        fetch_req  = 1'b0;
        chk("oor_fault", 64'(fault), 64'd1);
        chk("oor_fault_addr", 64'(fault_addr), 64'h400);
        chk("oor_ready", 64'(fetch_ready), 64'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        fetch(32'h3FC);
        drain("sb_empty_oor");

        // Reset in the same cycle as a request wins.
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        tick();
        fetch_req  = 1'b0;
        rst_n      = 1'b1;
        chk("rst_req_valid", 64'(fetch_valid), 64'd0);
        check_reset_state("rst_run");

        // Reset in the middle of a load keeps the memory contents.
        for (int i = 10; i < 20; i++) load(i, 32'hA000_0000 + 32'(i), 1'b0);
        chk("load_count_10", 64'(load_count), 64'd10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("rst_mid");
        load(1, 32'hCAFE_0001, 1'b0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("load_count_1", 64'(load_count), 64'd1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h28);
        fetch(32'h4C);
        drain("sb_empty_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised, clocked successor of the single-cycle instruction memory. It holds a word-addressed program store that is filled through a boot load port, then serves byte-addressed fetches with a one-cycle registered read and a valid/ready handshake. It detects misaligned and out-of-range fetch addresses and reports them as faults. It sits between the PC/fetch stage and the boot loader of the MIPS core.

## Interface
Parameters:
- WORD_SIZE, 32, instruction/data word width in bits
- DEPTH, 256, number of words; must be a power of two, at least 2
- ADDR_W, 32, fetch address width (byte address)
- IDX_W, clog2(DEPTH), derived localparam, word index width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- load_we  in  1  write strobe for the boot load port
- load_addr  in  IDX_W  word index to write
- load_data  in  WORD_SIZE  word to write
- load_done  in  1  one-cycle pulse; ends boot load
- fetch_req  in  1  fetch request; accepted when fetch_req && fetch_ready
- fetch_addr  in  ADDR_W  byte address of the requested instruction
- fault_clr  in  1  clears a fault and returns to RUN
- fetch_ready  out  1  block can accept a fetch this cycle
- fetch_valid  out  1  instruction holds the result of the fetch accepted last cycle
- instruction  out  WORD_SIZE  registered fetch data
- fault  out  1  sticky fault flag
- fault_addr  out  ADDR_W  address of the faulting fetch
- load_count  out  IDX_W+1  number of words written in BOOT; saturates at DEPTH

## Operation
- Three states: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT behaviour:
  - Each cycle with load_we=1 writes mem[load_addr] <= load_data.
  - Each such write increments load_count, saturating at DEPTH. Repeated writes to the same index still count.
  - fetch_ready=0. load_done=1 moves the state to RUN.
  - If load_we and load_done are both high in one cycle, the write commits and then the state moves to RUN.
- RUN behaviour:
  - fetch_ready=1; load_we is ignored.
  - An accepted fetch is classified by address:
    - Legal: fetch_addr[1:0]==0 and fetch_addr[ADDR_W-1:IDX_W+2]==0. The next cycle gives instruction=mem[fetch_addr[IDX_W+1:2]] and fetch_valid=1.
    - Illegal: either condition fails. The next cycle gives fetch_valid=0, fault=1, fault_addr=fetch_addr, state FAULT. instruction is unchanged.
- FAULT behaviour:
  - fetch_ready=0; fetch_req and load_we are ignored.
  - fault_clr=1 sets fault=0 and moves the state to RUN; fault_addr is retained.
  - fault_clr is ignored in BOOT and RUN.
- load_done is ignored outside BOOT. The only way to return to BOOT is reset.
- Memory contents are not cleared by reset. A reset in the middle of a load keeps the words already written, but load_count restarts at 0.

## Timing
- Reset values: fetch_valid=0, instruction=0, fault=0, fault_addr=0, load_count=0, fetch_ready=0 (state BOOT).
- Fetch latency is 1 cycle: a request accepted at edge N gives fetch_valid and instruction at edge N+1.
- Throughput is one fetch per cycle in RUN, back-to-back.
- fetch_valid is a one-cycle pulse for each accepted legal fetch. With no fetch, fetch_valid=0 and instruction holds its last value.
- fetch_ready is a combinational decode of state only; it does not depend on fetch_req.
- The transition BOOT→RUN takes effect on the edge that samples load_done. fetch_ready=1 from the following cycle.
- A faulting fetch at edge N sets fetch_ready=0 from N+1. fault_clr sampled at edge M gives fetch_ready=1 from M+1.
- A reset asserted in the same cycle as a request wins: no fetch_valid follows.

## Test plan
- Load mem[0..3]=0x20080001, 0x20090002, 0x01095020, 0xAC0A0000, then pulse load_done. Fetch addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four consecutive fetch_valid pulses with those words in order; load_count=4.
- Load with load_we and load_done in the same cycle (index 5, data 0xDEADBEEF), then fetch 0x14 -> instruction=0xDEADBEEF one cycle after acceptance.
- In RUN, fetch 0x6 (misaligned) -> fetch_valid=0, fault=1, fault_addr=0x6, fetch_ready=0. A further fetch_req gives no response. Pulse fault_clr -> fetch_ready=1; fetch 0x0 succeeds.
- With DEPTH=256, fetch 0x400 -> fault=1, fault_addr=0x400. Fetch 0x3FC -> legal, returns mem[255].
- While in BOOT, hold fetch_req=1 -> fetch_ready=0 and no fetch_valid. In RUN, assert load_we with index 0, data 0x0 -> mem[0] is unchanged on a later fetch.
- Write 10 words, assert rst_n=0 for one cycle mid-load, then reload index 1 only and pulse load_done -> load_count=1 and all outputs at reset values after reset. Fetch 0x0 returns the pre-reset mem[0] value.
